// File: rtl/fmul_issue_ctrl.sv
// Operand queue and single-op sequencer for the fp16/fp32 multiplier.
// Buffers operand pairs, issues one at a time, and holds the result until the consumer takes it.
module fmul_issue_ctrl #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_type,
    input  logic [31:0] s_a,
    input  logic [31:0] s_b,
    output logic        m_valid,
    output logic        m_data_type,
    output logic [31:0] m_in1_32,
    output logic [31:0] m_in2_32,
    output logic [15:0] m_in1_16,
    output logic [15:0] m_in2_16,
    input  logic        m_ready,
    input  logic [31:0] m_out_32,
    input  logic [15:0] m_out_16,
    input  logic        m_overflow,
    input  logic        m_error,
    output logic        r_valid,
    input  logic        r_ready,
    output logic        r_type,
    output logic [31:0] r_data,
    output logic [1:0]  r_flags,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_BUSY,
        S_CAPTURE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic          fifo_type [DEPTH];
    logic [31:0]   fifo_a    [DEPTH];
    logic [31:0]   fifo_b    [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic          empty, push, pop, full_nxt;
    logic          hd_type;
    logic [31:0]   hd_a, hd_b;

    assign empty      = (wr_ptr == rd_ptr);
    assign push       = s_valid && s_ready;
    // The head entry leaves the FIFO on the same edge it is latched into the issue registers.
    assign pop        = (state == S_IDLE) && !empty && m_ready && !r_valid;
    assign wr_ptr_nxt = push ? wr_ptr + PTR_ONE : wr_ptr;
    assign rd_ptr_nxt = pop  ? rd_ptr + PTR_ONE : rd_ptr;
    assign full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                        (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

    assign hd_type = fifo_type[rd_ptr[AW-1:0]];
    assign hd_a    = fifo_a[rd_ptr[AW-1:0]];
    assign hd_b    = fifo_b[rd_ptr[AW-1:0]];

    assign busy = (state != S_IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_type[wr_ptr[AW-1:0]] <= s_type;
            fifo_a[wr_ptr[AW-1:0]]    <= s_a;
            fifo_b[wr_ptr[AW-1:0]]    <= s_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            s_ready <= 1'b1;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            s_ready <= !full_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            m_valid     <= 1'b0;
            m_data_type <= 1'b0;
            m_in1_32    <= '0;
            m_in2_32    <= '0;
            m_in1_16    <= '0;
            m_in2_16    <= '0;
            r_valid     <= 1'b0;
            r_type      <= 1'b0;
            r_data      <= '0;
            r_flags     <= '0;
        end else begin
            m_valid <= 1'b0;
            if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        state       <= S_ISSUE;
                        m_valid     <= 1'b1;
                        m_data_type <= hd_type;
                        m_in1_32    <= hd_type ? hd_a : '0;
                        m_in2_32    <= hd_type ? hd_b : '0;
                        m_in1_16    <= hd_type ? '0 : hd_a[15:0];
                        m_in2_16    <= hd_type ? '0 : hd_b[15:0];
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!m_ready) begin
                        state <= S_BUSY;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_CAPTURE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_BUSY: begin
                    if (m_ready) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_valid <= 1'b1;
                    r_type  <= m_data_type;
                    r_data  <= m_data_type ? m_out_32 : {16'h0000, m_out_16};
                    r_flags <= {m_error, m_overflow};
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// Bench for fmul_issue_ctrl: directed vectors, multi-cycle corner sequences and a
// randomized run checked by an operand/result scoreboard around a behavioural multiplier.
`timescale 1ns/1ps
module tb_fmul_issue_ctrl;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0, s_ready, s_type = 1'b0;
    logic [31:0] s_a = '0, s_b = '0;
    logic        m_valid, m_data_type;
    logic [31:0] m_in1_32, m_in2_32;
    logic [15:0] m_in1_16, m_in2_16;
    logic        m_ready = 1'b1;
    logic [31:0] m_out_32 = '0;
    logic [15:0] m_out_16 = '0;
    logic        m_overflow = 1'b0, m_error = 1'b0;
    logic        r_valid, r_ready = 1'b0, r_type;
    logic [31:0] r_data;
    logic [1:0]  r_flags;
    logic        busy;

    always #5 clk = ~clk;

    fmul_issue_ctrl #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_type(s_type), .s_a(s_a), .s_b(s_b),
        .m_valid(m_valid), .m_data_type(m_data_type),
        .m_in1_32(m_in1_32), .m_in2_32(m_in2_32), .m_in1_16(m_in1_16), .m_in2_16(m_in2_16),
        .m_ready(m_ready), .m_out_32(m_out_32), .m_out_16(m_out_16),
        .m_overflow(m_overflow), .m_error(m_error),
        .r_valid(r_valid), .r_ready(r_ready), .r_type(r_type), .r_data(r_data),
        .r_flags(r_flags), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    typedef struct packed { logic t; logic [31:0] a; logic [31:0] b; } op_t;
    typedef struct packed { logic t; logic [31:0] d; logic [1:0] f; } res_t;
    op_t  in_q[$];
    res_t res_q[$];

    // Multiplier behaviour: {error, overflow, result}; known float products, otherwise a scramble.
    function automatic logic [33:0] mul_model(input logic t, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] o;
        if (t && a == 32'h3FC00000 && b == 32'h40000000) return {2'b00, 32'h40400000};
        if (t && a == 32'h7FC00000)                      return {2'b10, 32'h7FFFFFFF};
        if (t && a == 32'h7F000000 && b == 32'h7F000000) return {2'b01, 32'h7F800000};
        if (!t && (a[15:0] == 16'h0000 || b[15:0] == 16'h0000)) return {2'b00, 32'h0};
        if (!t && a[15:0] == 16'h3C00 && b[15:0] == 16'h4000)   return {2'b00, 32'h00004000};
        o = (a ^ {b[15:0], b[31:16]}) + 32'h01234567;
        return {b[5], a[3], t ? o : {16'h0000, o[15:0]}};
    endfunction

    int   cyc = 0, issue_cyc = 0, rv_cyc = 0;
    int   n_issue = 0, n_res = 0, n_rv = 0;
    int   busy_cnt = 0, drop_pend = 0;
    int   drop_mode = 0;
    logic hold_low = 1'b0;
    logic rr_rand = 1'b0;
    logic rv_prev = 1'b0, rr_prev = 1'b0;
    logic [34:0] r_prev = '0;

    // Monitor, scoreboard and multiplier model, all evaluated on the falling edge.
    initial begin
        op_t         o;
        res_t        r;
        logic [33:0] mr;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                in_q.delete();
                res_q.delete();
                busy_cnt  = 0;
                drop_pend = 0;
                m_ready   = !hold_low;
                rv_prev   = 1'b0;
                rr_prev   = 1'b0;
            end else begin
                if (m_valid) chk("mvalid_while_ready", m_ready, 1'b1);
                if (busy_cnt > 0) busy_cnt--;
                if (drop_pend > 0) begin
                    busy_cnt  = drop_pend;
                    drop_pend = 0;
                end
                m_ready = !hold_low && (busy_cnt == 0);

                if (s_valid && s_ready) in_q.push_back(op_t'({s_type, s_a, s_b}));

                if (m_valid) begin
                    chk("one_in_flight", res_q.size(), 0);
                    if (in_q.size() == 0) begin
                        fail_now("issue_without_push");
                    end else begin
                        o = in_q.pop_front();
                        chk("issue_operands",
                            {m_data_type, m_in1_32, m_in2_32, m_in1_16, m_in2_16},
                            {o.t, o.t ? o.a : 32'h0, o.t ? o.b : 32'h0,
                             o.t ? 16'h0 : o.a[15:0], o.t ? 16'h0 : o.b[15:0]});
                        mr = mul_model(o.t, o.a, o.b);
                        m_out_32   = o.t ? mr[31:0] : 32'hBAD0BAD0;
                        m_out_16   = o.t ? 16'hBAD1 : mr[15:0];
                        m_error    = mr[33];
                        m_overflow = mr[32];
                        res_q.push_back(res_t'({o.t, o.t ? mr[31:0] : {16'h0000, mr[15:0]}, mr[33:32]}));
                        drop_pend = (drop_mode >= 0) ? drop_mode : int'($urandom_range(0, 3));
                    end
                    issue_cyc = cyc;
                    n_issue++;
                end

                if (r_valid && !rv_prev) begin
                    rv_cyc = cyc;
                    n_rv++;
                end
                if (r_valid && rv_prev && !rr_prev) chk("result_held", {r_type, r_data, r_flags}, r_prev);
                if (r_valid && r_ready) begin
                    if (res_q.size() == 0) begin
                        fail_now("result_without_issue");
                    end else begin
                        r = res_q.pop_front();
                        chk("result_order", {r_type, r_data, r_flags}, {r.t, r.d, r.f});
                    end
                    n_res++;
                end
                rv_prev = r_valid;
                rr_prev = r_ready;
                r_prev  = {r_type, r_data, r_flags};
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_rand) r_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout actual=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic t, input logic [31:0] a, input logic [31:0] b);
        logic acc;
        int   n;
        s_valid = 1'b1; s_type = t; s_a = a; s_b = b;
        acc = 1'b0; n = 0;
        while (!acc && n < 3000) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        if (!acc) fail_now("push_accept");
    endtask

    task automatic wait_rvalid(input string name, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            #1;
            ok = r_valid;
        end
        if (!ok) fail_now(name);
    endtask

    task automatic wait_nres(input string name, input int target, input int bound);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < bound && !ok; k++) begin
            @(negedge clk);
            #1;
            ok = (n_res >= target);
        end
        if (!ok) fail_now(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1'b1);
        chk({tag, "_m_side"}, {m_valid, m_data_type, m_in1_32, m_in2_32, m_in1_16, m_in2_16}, '0);
        chk({tag, "_r_side"}, {r_valid, r_type, r_data, r_flags}, '0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    typedef struct {
        logic        t;
        logic [31:0] a;
        logic [31:0] b;
        int          drop;
        logic [31:0] exp_d;
        logic [1:0]  exp_f;
        int          lat;
    } vec_t;
    vec_t tv[6];

    initial begin
        logic        ok;
        int          base_res, base_iss, base_rv;
        logic [34:0] held;

        tv[0] = '{1'b1, 32'h3FC00000, 32'h40000000, 2, 32'h40400000, 2'b00, 5};
        tv[1] = '{1'b0, 32'h00000000, 32'h00003C00, 0, 32'h00000000, 2'b00, SETTLE + 2};
        tv[2] = '{1'b1, 32'h7FC00000, 32'h3F800000, 0, 32'h7FFFFFFF, 2'b10, SETTLE + 2};
        tv[3] = '{1'b0, 32'h00003C00, 32'h00004000, 0, 32'h00004000, 2'b00, SETTLE + 2};
        tv[4] = '{1'b1, 32'h7F000000, 32'h7F000000, 1, 32'h7F800000, 2'b01, 4};
        tv[5] = '{1'b0, 32'hFFFF3C00, 32'h12344000, 0, 32'h00004000, 2'b00, SETTLE + 2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        to_drive();
        rst_n = 1'b1;
        to_drive();

        for (int i = 0; i < 6; i++) begin
            drop_mode = tv[i].drop;
            base_iss  = n_issue;
            push_op(tv[i].t, tv[i].a, tv[i].b);
            wait_rvalid("vec_rvalid", ok);
            if (ok) begin
                chk($sformatf("vec%0d_type", i), r_type, tv[i].t);
                chk($sformatf("vec%0d_data", i), r_data, tv[i].exp_d);
                chk($sformatf("vec%0d_flags", i), r_flags, tv[i].exp_f);
                chk($sformatf("vec%0d_latency", i), rv_cyc - issue_cyc, tv[i].lat);
                chk($sformatf("vec%0d_issues", i), n_issue - base_iss, 1);
            end
            to_drive();
            r_ready = 1'b1;
            to_drive();
            r_ready = 1'b0;
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d_rvalid_clear", i), r_valid, 1'b0);
            to_drive();
        end

        // Five pushes against a stalled multiplier: the fifth waits for the first pop.
        drop_mode = 0;
        hold_low  = 1'b1;
        r_ready   = 1'b1;
        to_drive();
        to_drive();
        base_res = n_res;
        base_iss = n_issue;
        for (int k = 0; k < 4; k++) push_op(1'b1, 32'h40000000 + k, 32'h3F800000 + k);
        chk("fifo_full_sready", s_ready, 1'b0);
        chk("fifo_full_busy", busy, 1'b1);
        s_valid = 1'b1; s_type = 1'b0; s_a = 32'h00001234; s_b = 32'h00005678;
        repeat (3) to_drive();
        chk("fifo_full_hold", {s_ready, 32'(n_issue - base_iss)}, {1'b0, 32'd0});
        hold_low = 1'b0;
        push_op(1'b0, 32'h00001234, 32'h00005678);
        wait_nres("fifo_drain", base_res + 5, 500);
        chk("fifo_results", n_res - base_res, 5);

        // Consumer stall with two ops queued.
        to_drive();
        r_ready  = 1'b0;
        base_iss = n_issue;
        base_res = n_res;
        push_op(1'b1, 32'h3FC00000, 32'h40000000);
        push_op(1'b0, 32'h00003C00, 32'h00004000);
        wait_rvalid("stall_rvalid", ok);
        held = {r_type, r_data, r_flags};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("stall_hold", {r_valid, r_type, r_data, r_flags}, {1'b1, held});
        end
        chk("stall_no_second_issue", n_issue - base_iss, 1);
        to_drive();
        r_ready = 1'b1;
        wait_nres("stall_drain", base_res + 2, 200);
        chk("stall_issues", n_issue - base_iss, 2);

        // Reset while the multiplier holds the op in BUSY.
        to_drive();
        drop_mode = 8;
        base_iss  = n_issue;
        push_op(1'b1, 32'h40400000, 32'h40400000);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            #1;
            ok = (n_issue != base_iss);
        end
        if (!ok) fail_now("busy_issue");
        repeat (3) to_drive();
        chk("busy_before_reset", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("midop_reset");
        to_drive();
        drop_mode = 0;
        base_rv   = n_rv;
        rst_n     = 1'b1;
        repeat (20) to_drive();
        chk("midop_no_result", {32'(n_rv - base_rv), r_valid, busy, s_ready}, {32'd0, 1'b0, 1'b0, 1'b1});

        // Randomized traffic with random multiplier stalls and consumer back-pressure.
        drop_mode = -1;
        rr_rand   = 1'b1;
        base_res  = n_res;
        for (int i = 0; i < 150; i++) begin
            push_op(1'($urandom_range(0, 1)), $urandom, $urandom);
            repeat ($urandom_range(0, 2)) to_drive();
        end
        wait_nres("random_drain", base_res + 150, 20000);
        chk("random_results", n_res - base_res, 150);
        rr_rand = 1'b0;
        to_drive();
        r_ready = 1'b1;
        repeat (3) to_drive();
        chk("final_idle", {busy, r_valid, 32'(res_q.size()), 32'(in_q.size())}, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
